// File: rtl/knight_pkg.sv
// Shared types and constants for the knight_scan LED scanner.
package knight_pkg;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } knight_dir_t;

   localparam logic KNIGHT_BOUNCE = 1'b0;
   localparam logic KNIGHT_WRAP   = 1'b1;

endpackage

// File: rtl/knight_prescale.sv
// Step-rate divider for knight_scan: one tick every DIV enabled cycles.
module knight_prescale #(
   parameter int DIV = 1
) (
   input  logic ck,
   input  logic res_n,
   input  logic en,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // A partial count survives en dropping, so the next step lands where it would have.
   always_ff @(posedge ck or negedge res_n) begin
      if (!res_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   // Gated by res_n so the strobe is quiet the moment reset asserts.
   assign tick = en && res_n && (cnt == LAST);

endmodule

// File: rtl/knight_scan.sv
// Parametrised bounce/wrap LED scanner; define KNIGHT_SCAN_TRAIL_EN to light
// the TRAIL-1 most recent head positions behind the head.
module knight_scan
   import knight_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DIV   = 1,
   parameter  int TRAIL = 3,
   localparam int PW    = $clog2(WIDTH)
) (
   input  logic             ck,
   input  logic             res_n,
   input  logic             en,
   input  logic             mode,
   output logic [WIDTH-1:0] out,
   output logic [PW-1:0]    pos,
   output logic             dir,
   output logic             tick
);

   localparam logic [PW-1:0] LAST    = PW'(WIDTH - 1);
   localparam logic [PW-1:0] LAST_M1 = PW'(WIDTH - 2);
   localparam logic [PW-1:0] ONE     = PW'(1);

   knight_dir_t     state, state_nx;
   logic [PW-1:0]   pos_nx;
   logic [WIDTH-1:0] trail_mask;

   knight_prescale #(.DIV(DIV)) u_prescale (
      .ck    (ck),
      .res_n (res_n),
      .en    (en),
      .tick  (tick)
   );

   always_ff @(posedge ck or negedge res_n) begin
      if (!res_n) begin
         state <= UP;
         pos   <= '0;
      end else begin
         state <= state_nx;
         pos   <= pos_nx;
      end
   end

   // Wrap keeps the direction; bounce turns at the ends, including a head left
   // sitting on an end lamp by an earlier mode switch.
   always_comb begin
      state_nx = state;
      pos_nx   = pos;
      if (tick) begin
         if (mode == KNIGHT_WRAP) begin
            if (state == UP) pos_nx = (pos == LAST) ? '0 : pos + ONE;
            else             pos_nx = (pos == '0) ? LAST : pos - ONE;
         end else if (state == UP) begin
            if (pos == LAST) begin
               pos_nx   = LAST_M1;
               state_nx = DOWN;
            end else if (pos >= LAST_M1) begin
               pos_nx   = LAST;
               state_nx = DOWN;
            end else begin
               pos_nx   = pos + ONE;
            end
         end else begin
            if (pos <= ONE) begin
               pos_nx   = '0;
               state_nx = UP;
            end else begin
               pos_nx   = pos - ONE;
            end
         end
      end
   end

`ifdef KNIGHT_SCAN_TRAIL_EN
   localparam int   HN = (TRAIL > 1) ? TRAIL - 1 : 1;
   localparam logic HV = (TRAIL > 1);

   logic [PW-1:0] hist_pos [HN];
   logic [HN-1:0] hist_vld;

   // Entry 0 is the most recent previous head; only reset clears the history.
   always_ff @(posedge ck or negedge res_n) begin
      if (!res_n) begin
         for (int i = 0; i < HN; i++) hist_pos[i] <= '0;
         hist_vld <= '0;
      end else if (tick) begin
         hist_pos[0] <= pos;
         hist_vld[0] <= HV;
         for (int i = 1; i < HN; i++) begin
            hist_pos[i] <= hist_pos[i-1];
            hist_vld[i] <= hist_vld[i-1];
         end
      end
   end

   always_comb begin
      trail_mask = '0;
      for (int i = 0; i < HN; i++) begin
         if (hist_vld[i]) trail_mask[hist_pos[i]] = 1'b1;
      end
   end
`else
   assign trail_mask = '0;
`endif

   always_comb begin
      out      = trail_mask;
      out[pos] = 1'b1;
   end

   assign dir = state;

endmodule

// File: doc/knight_scan.md
# knight_scan

Parametrised LED scanner, successor to the fixed 8-bit `knight1`. It drives a WIDTH-bit one-hot pattern at a rate set by an internal prescaler, in one of two modes: bounce (Knight Rider sweep) or wrap (rotate). It has an enable input and reports direction and position, so the panel/top level can chain and observe it. An optional compiled-in trail lights the most recent positions behind the head.

## Interface
- `WIDTH`, 8: number of output lamps; legal range ≥ 2.
- `DIV`, 1: enabled clock cycles per step; legal range ≥ 1.
- `TRAIL`, 3: total lit positions, head included. Used only with `KNIGHT_SCAN_TRAIL_EN`; legal range 1..WIDTH.
- `ck` input 1: clock; all state updates on the rising edge.
- `res_n` input 1: reset, asynchronous assert, active-low.
- `en` input 1: count enable; while 0 the prescaler and pattern hold.
- `mode` input 1: 0 = bounce, 1 = wrap; sampled only on step cycles.
- `out` output WIDTH: lamp pattern.
- `pos` output $clog2(WIDTH): index of the head lamp.
- `dir` output 1: 0 = moving toward MSB (UP), 1 = toward LSB (DOWN); equals FSM state.
- `tick` output 1: one-cycle step strobe.

## Operation
- Reset values (res_n low, immediate): prescaler = 0, pos = 0, state UP (dir = 0), trail history invalid, tick = 0, out = 1 (bit 0 only).
- Prescaler: cnt counts 0..DIV-1 on cycles where en = 1.
  - tick = en && cnt == DIV-1; cnt wraps to 0 on that cycle.
  - DIV = 1 gives tick = en.
- FSM states UP and DOWN. It advances only on edges where tick = 1.
- Bounce (mode = 0):
  - UP: if pos ≥ WIDTH-2, set pos = WIDTH-1 and go to DOWN. Otherwise pos + 1.
  - UP with pos == WIDTH-1 (reached after a mode switch): pos = WIDTH-2, go to DOWN.
  - DOWN: if pos ≤ 1, set pos = 0 and go to UP. Otherwise pos - 1.
  - Period is 2·(WIDTH-1) ticks. The end lamps are lit for one step, with no dwell.
- Wrap (mode = 1):
  - UP: pos + 1, with WIDTH-1 → 0.
  - DOWN: pos - 1, with 0 → WIDTH-1.
  - State is unchanged, so the scan keeps its current direction.
- Mode changes take effect on the next tick, from the current pos and state. There is no reset of position.
- `out` = one-hot(pos), optionally OR-ed with the trail (see Configuration).
- Index arithmetic is done in $clog2(WIDTH) bits. WIDTH need not be a power of 2, and pos never exceeds WIDTH-1.

## Timing
- `pos`, `dir` and `out` change only on the ck edge at which tick = 1. They are valid immediately after that edge, with zero extra latency.
- First step after reset release happens DIV enabled cycles later.
- When en drops, the cycle count freezes mid-count and resumes where it stopped. Partial counts are not lost.
- `res_n` asserted mid-scan: all outputs return to reset values within the same cycle, with no dependence on ck. Release is synchronised externally by the top level.
- `tick` is combinational from cnt and en. It must not be used as a clock.

## Configuration
- `KNIGHT_SCAN_TRAIL_EN` defined:
  - Keep a history of the last TRAIL-1 head positions, each with a valid bit. On each tick, shift the old pos in.
  - `out` = one-hot(pos) OR one-hot(each valid history entry).
  - Coincident positions (the bounce turnaround) simply overlap.
  - History is cleared by reset only. Mode changes do not clear it.
- Not defined: no history registers; `out` is strictly one-hot; TRAIL is ignored.

## Structure
- Package `knight_pkg`:
  - state enum `knight_dir_t` {UP = 0, DOWN = 1};
  - mode constants `KNIGHT_BOUNCE = 0`, `KNIGHT_WRAP = 1`.
- Sub-module `knight_prescale` (parameter DIV; ports ck, res_n, en, tick) holds the divider. The scan FSM, trail and decoder stay in `knight_scan`.

## Test plan
- **Bounce sweep.** WIDTH = 8, DIV = 1, mode 0, en 1:
  - out = 00000001 at reset;
  - after 7 ticks out = 10000000, dir = 1;
  - after 8 ticks out = 01000000;
  - after 14 ticks out = 00000001, dir = 0.
- **Wrap, with direction held.** Mode 1:
  - after 8 ticks out = 00000001 again, with dir = 0 throughout;
  - switching to wrap while DOWN at pos 2 gives 1, 0, then 7.
- **Prescale and enable.** DIV = 3:
  - out changes every 3rd cycle;
  - dropping en for 5 cycles after count 1 then re-raising gives the next step 2 enabled cycles later.
- **Async reset mid-scan.** At pos 5, DOWN, pull res_n low between edges:
  - out = 00000001, pos = 0, dir = 0, tick = 0 before the next ck edge.
- **Trail.** With `KNIGHT_SCAN_TRAIL_EN`, TRAIL = 3:
  - after 2 ticks out = 00000111;
  - after 8 ticks out = 11000000 (pos 6, history 7 and 6).
- **Edge width.** WIDTH = 2 bounce: out alternates 01 and 10 every tick, and dir toggles every tick.
